// File: rtl/coarse_attenuator_if.sv
// Sample/control bundle for the coarse attenuator: the source drives samples and
// the shift request, and the attenuator returns shifted samples plus its status.
`timescale 1ns/1ps

interface coarse_attenuator_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] data_i;
  logic                    valid_i;
  logic [2:0]              adj_i;
  logic signed [WIDTH-1:0] data_o;
  logic                    valid_o;
  logic [2:0]              adj_active_o;
  logic                    muted_o;

  modport master (
    output data_i, valid_i, adj_i,
    input  data_o, valid_o, adj_active_o, muted_o
  );

  modport slave (
    input  data_i, valid_i, adj_i,
    output data_o, valid_o, adj_active_o, muted_o
  );
endinterface

// File: rtl/coarse_attenuator.sv
// Two-stage signed arithmetic right shift (divide by 2^k, round half up) with a
// muted hand-over window whenever the requested shift changes.
`timescale 1ns/1ps

module coarse_attenuator #(
  parameter int WIDTH        = 16,
  parameter int HOLD_SAMPLES = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  coarse_attenuator_if.slave bus
);

  typedef enum logic {ST_RUN, ST_MUTE} state_e;

  localparam logic [7:0] HOLD = 8'(HOLD_SAMPLES);

  state_e                  state_q;
  logic [2:0]              adj_active_q;
  logic [2:0]              pending_q;
  logic [7:0]              cnt_q;

  logic signed [WIDTH-1:0] s1_data_q;
  logic                    s1_valid_q;
  logic [2:0]              s1_k_q;
  logic                    s1_mute_q;

  logic signed [WIDTH-1:0] data_q;
  logic                    valid_q;

  logic [WIDTH:0]          rnd_d;
  logic signed [WIDTH:0]   sum_d;
  logic signed [WIDTH-1:0] data_d;

  // Shift-control FSM. The counter only advances on valid samples, so the mute
  // window is measured in samples rather than clock cycles.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and reset is synchronous (checked inside the edge).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      adj_active_q <= '0;
      pending_q    <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.adj_i != adj_active_q) begin
            if (HOLD_SAMPLES > 0) begin
              state_q   <= ST_MUTE;
              cnt_q     <= HOLD;
              pending_q <= bus.adj_i;
            end else begin
              adj_active_q <= bus.adj_i;
            end
          end
        end
        ST_MUTE: begin
          if (bus.adj_i != pending_q) begin
            pending_q <= bus.adj_i;
            cnt_q     <= HOLD;
          end else if (bus.valid_i) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              adj_active_q <= pending_q;
              state_q      <= ST_RUN;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Rounding constant 2^(k-1) is added in WIDTH+1 bits so the sum cannot wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rnd_d = '0;
    if (s1_k_q != 3'd0) begin
      rnd_d = (WIDTH+1)'(1) << (s1_k_q - 3'd1);
    end
    sum_d  = {s1_data_q[WIDTH-1], s1_data_q} + $signed(rnd_d);
    data_d = s1_mute_q ? '0 : WIDTH'(sum_d >>> s1_k_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_k_q     <= '0;
      s1_mute_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      s1_data_q  <= bus.data_i;
      s1_valid_q <= bus.valid_i;
      s1_k_q     <= adj_active_q;
      s1_mute_q  <= (state_q == ST_MUTE);
      valid_q    <= s1_valid_q;
      if (s1_valid_q) begin
        data_q <= data_d;
      end
    end
  end

  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign bus.adj_active_o = adj_active_q;
  assign bus.muted_o      = (state_q == ST_MUTE);

endmodule

// File: tb/tb_coarse_attenuator.sv
// Bench for coarse_attenuator: directed vectors and sequences plus a randomized
// run, all scored against a sample-level reference model of both build variants.
`timescale 1ns/1ps

module tb_coarse_attenuator;

  localparam int WIDTH = 16;
  localparam int NM    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coarse_attenuator_if #(.WIDTH(WIDTH)) bus0 ();
  coarse_attenuator_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus1.data_i  = bus0.data_i;
  assign bus1.valid_i = bus0.valid_i;
  assign bus1.adj_i   = bus0.adj_i;

  coarse_attenuator #(.WIDTH(WIDTH), .HOLD_SAMPLES(8)) dut_hold8 (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );
  coarse_attenuator #(.WIDTH(WIDTH), .HOLD_SAMPLES(0)) dut_hold0 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit sb_en    = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round half toward +inf of x / 2^k, straight from the arithmetic definition.
  function automatic int round_shift(input int x, input int k);
    if (k == 0) return x;
    return int'($floor(real'(x) / (2.0 ** k) + 0.5));
  endfunction

  // Reference model: one sample in flight between acceptance and output, plus
  // the mute/hand-over rules expressed per accepted sample.
  int hold_m   [NM] = '{8, 0};
  bit m_mute   [NM];
  int m_active [NM];
  int m_pending[NM];
  int m_count  [NM];
  bit fl_v     [NM];
  int fl_d     [NM];
  int exp_data [NM];
  bit exp_valid[NM];

  always @(posedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (rst) begin
        m_mute[m] = 0; m_active[m] = 0; m_pending[m] = 0; m_count[m] = 0;
        fl_v[m] = 0; fl_d[m] = 0; exp_data[m] = 0; exp_valid[m] = 0;
      end else begin
        int adj;
        adj = int'(bus0.adj_i);
        if (fl_v[m]) exp_data[m] = fl_d[m];
        exp_valid[m] = fl_v[m];
        fl_v[m] = bus0.valid_i;
        fl_d[m] = m_mute[m] ? 0 : round_shift(int'($signed(bus0.data_i)), m_active[m]);
        if (!m_mute[m]) begin
          if (adj != m_active[m]) begin
            if (hold_m[m] > 0) begin
              m_mute[m] = 1; m_count[m] = hold_m[m]; m_pending[m] = adj;
            end else begin
              m_active[m] = adj;
            end
          end
        end else if (adj != m_pending[m]) begin
          m_pending[m] = adj; m_count[m] = hold_m[m];
        end else if (bus0.valid_i) begin
          m_count[m]--;
          if (m_count[m] == 0) begin
            m_active[m] = m_pending[m]; m_mute[m] = 0;
          end
        end
      end
    end
  end

  logic signed [WIDTH-1:0] dut_data [NM];
  logic                    dut_valid[NM];
  logic [2:0]              dut_adj  [NM];
  logic                    dut_muted[NM];
  assign dut_data[0]  = bus0.data_o;       assign dut_data[1]  = bus1.data_o;
  assign dut_valid[0] = bus0.valid_o;      assign dut_valid[1] = bus1.valid_o;
  assign dut_adj[0]   = bus0.adj_active_o; assign dut_adj[1]   = bus1.adj_active_o;
  assign dut_muted[0] = bus0.muted_o;      assign dut_muted[1] = bus1.muted_o;

  always @(negedge clk) begin
    if (sb_en) begin
      for (int m = 0; m < NM; m++) begin
        check($sformatf("sb%0d valid_o", m), dut_valid[m], int'(exp_valid[m]));
        check($sformatf("sb%0d data_o", m), dut_data[m], exp_data[m]);
        check($sformatf("sb%0d adj_active_o", m), dut_adj[m], m_active[m]);
        check($sformatf("sb%0d muted_o", m), dut_muted[m], int'(m_mute[m]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit v, input int k);
    bus0.data_i  = WIDTH'(d);
    bus0.valid_i = v;
    bus0.adj_i   = 3'(k);
  endtask

  task automatic settle(input int k, input int d);
    drive(d, 1'b1, k);
    repeat (14) tick();
  endtask

  typedef struct {
    int din;
    int k;
    int exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int zeros, first_nz, muted_cycles, last_val;
    bit seen, prev_muted, saw250;

    vecs[0]  = '{7, 1, 4};        vecs[1]  = '{-3, 1, -1};
    vecs[2]  = '{-4, 1, -2};      vecs[3]  = '{32767, 1, 16384};
    vecs[4]  = '{-32768, 1, -16384}; vecs[5] = '{-1, 1, 0};
    vecs[6]  = '{7, 7, 0};        vecs[7]  = '{-3, 7, 0};
    vecs[8]  = '{-4, 7, 0};       vecs[9]  = '{32767, 7, 256};
    vecs[10] = '{-32768, 7, -256}; vecs[11] = '{-1, 7, 0};

    // Reset state
    rst = 1'b1;
    drive(0, 1'b0, 0);
    repeat (3) tick();
    check("reset data_o", bus0.data_o, 0);
    check("reset valid_o", bus0.valid_o, 0);
    check("reset adj_active_o", bus0.adj_active_o, 0);
    check("reset muted_o", bus0.muted_o, 0);
    sb_en = 1'b1;
    rst   = 1'b0;

    // Ramp at k=0: output equals input, valid delayed by two cycles
    for (int i = 0; i < 12; i++) begin
      drive(i, i < 10, 0);
      tick();
      check("ramp valid_o", bus0.valid_o, int'(i >= 1 && i <= 10));
      if (i >= 1 && i <= 10) check("ramp data_o", bus0.data_o, i - 1);
      check("ramp muted_o", bus0.muted_o, 0);
    end

    // Rounding table
    for (int i = 0; i < 12; i++) begin
      if (int'(bus0.adj_active_o) != vecs[i].k) settle(vecs[i].k, 0);
      drive(vecs[i].din, 1'b1, vecs[i].k);
      tick();
      drive(0, 1'b0, vecs[i].k);
      tick();
      check($sformatf("round %0d k=%0d", vecs[i].din, vecs[i].k), bus0.data_o, vecs[i].exp);
    end

    // Change 0 -> 3 with continuous input 1000
    settle(0, 1000);
    zeros = 0; first_nz = 0; seen = 0; prev_muted = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1000, 1'b1, 3);
      tick();
      if (bus0.muted_o && !prev_muted) check("change adj before", bus0.adj_active_o, 0);
      if (!bus0.muted_o && prev_muted) check("change adj after", bus0.adj_active_o, 3);
      prev_muted = bus0.muted_o;
      if (bus0.valid_o && !seen) begin
        if (bus0.data_o == 0) zeros++;
        else if (zeros > 0) begin seen = 1; first_nz = int'(bus0.data_o); end
      end
    end
    check("change zero count", zeros, 8);
    check("change first value", first_nz, 125);

    // Bubbles during mute
    settle(0, 1000);
    zeros = 0; muted_cycles = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1000, (i % 2) == 0, 3);
      tick();
      if (bus0.muted_o) muted_cycles++;
      if (bus0.valid_o && bus0.data_o == 0) zeros++;
      if (bus0.valid_o && bus0.data_o == 125) seen = 1;
    end
    check("bubble muted cycles", muted_cycles, 16);
    check("bubble zero count", zeros, 8);
    check("bubble reaches 125", int'(seen), 1);

    // Re-change mid-mute: 0 -> 2, three valid samples, then 2 -> 5
    settle(0, 1000);
    zeros = 0; saw250 = 0; last_val = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 4)       drive(1000, 1'b1, 2);
      else if (i == 4) drive(1000, 1'b0, 5);
      else             drive(1000, 1'b1, 5);
      tick();
      if (bus0.valid_o) begin
        if (bus0.data_o == 0) zeros++;
        if (bus0.data_o == 250) saw250 = 1;
        last_val = int'(bus0.data_o);
      end
    end
    check("rechange zero count", zeros, 11);
    check("rechange no 250", int'(saw250), 0);
    check("rechange final", last_val, 31);

    // Zero-hold build: change is immediate and no sample is zeroed
    settle(0, 1000);
    drive(1000, 1'b1, 4);
    tick();
    check("hold0 adj_active_o", bus1.adj_active_o, 4);
    check("hold0 muted_o", bus1.muted_o, 0);
    check("hold8 muted_o", bus0.muted_o, 1);
    tick();
    check("hold0 old-k sample", bus1.data_o, 1000);
    tick();
    check("hold0 new-k sample", bus1.data_o, 63);

    // Reset while the counter sits at 4
    settle(0, 1000);
    drive(1000, 1'b1, 1);
    repeat (5) tick();
    check("pre-reset muted_o", bus0.muted_o, 1);
    rst = 1'b1;
    tick();
    check("midmute rst data_o", bus0.data_o, 0);
    check("midmute rst valid_o", bus0.valid_o, 0);
    check("midmute rst adj_active_o", bus0.adj_active_o, 0);
    check("midmute rst muted_o", bus0.muted_o, 0);
    rst = 1'b0;
    repeat (20) tick();

    // Randomized run against the model
    for (int i = 0; i < 2500; i++) begin
      int d;
      d = int'($urandom);
      case ($urandom_range(0, 9))
        0: d = 32767;
        1: d = -32768;
        default: ;
      endcase
      bus0.data_i  = WIDTH'(d);
      bus0.valid_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) bus0.adj_i = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
